apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one APB_MASTER instance between four requesters (e.g. DMA, CPU bridge, config loader, debug port).
- Latches the winning requester's command and drives the master's transfer, READ_WRITE, address and write-data inputs.
- Tracks the master's PSEL1/PENABLE/PREADY phases, captures read data, and returns a one-cycle completion pulse to the granted requester.
- Sits between the requester fabric and APB_MASTER; the master and slaves are unchanged.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- WAIT_LIMIT, 16, ACCESS-phase wait cycles before the stall flag sets (1..255).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req  in  4  per-requester request level; held until that requester's done.
- req_rw  in  4  per-requester direction; 1 = write, 0 = read.
- req_addr  in  4*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- req_wdata  in  4*DATA_W  packed write data, same packing.
- gnt  out  4  one-hot grant; held for the whole transaction.
- done  out  4  one-hot completion pulse, one cycle.
- rdata  out  DATA_W  read data; valid in the cycle done is asserted for a read.
- stall  out  1  sticky flag: the current ACCESS phase exceeded WAIT_LIMIT cycles; cleared on the next grant.
- transfer  out  1  to master transfer.
- READ_WRITE  out  1  to master READ_WRITE.
- apb_write_paddr  out  ADDR_W  to master.
- apb_write_data  out  DATA_W  to master.
- apb_read_paddr  out  ADDR_W  to master.
- m_psel  in  1  from master PSEL1.
- m_penable  in  1  from master PENABLE.
- PREADY  in  1  slave ready, shared with master.
- prdata  in  DATA_W  slave read data, shared with master.

Behaviour:
- Reset (asynchronous, active-high):
  - gnt, done, rdata, stall, transfer, READ_WRITE and all address/data outputs = 0.
  - State = IDLE. Round-robin pointer last = 3, so requester 0 has first priority.
  - Wait counter = 0.
- States: IDLE -> ISSUE -> WAIT_SETUP -> WAIT_ACCESS -> DONE -> IDLE.
- IDLE, when req != 0:
  - Winner = first set bit scanning last+1, last+2, … modulo 4.
  - Register the winner's gnt bit, rw, addr and wdata.
  - Clear stall and go to ISSUE.
- ISSUE:
  - transfer = 1.
  - READ_WRITE = latched rw.
  - apb_write_paddr = apb_read_paddr = latched addr.
  - apb_write_data = latched wdata for writes, 0 for reads.
  - Go to WAIT_SETUP.
- WAIT_SETUP:
  - Hold transfer = 1 until m_psel = 1 and m_penable = 0 is seen.
  - In that cycle drive transfer = 0 and go to WAIT_ACCESS.
  - Dropping transfer is what makes the master return to IDLE after ACCESS; the arbiter never requests master back-to-back chaining.
- WAIT_ACCESS:
  - Addr/data/READ_WRITE stay stable.
  - Completion = m_psel & m_penable & PREADY. On completion:
    - rdata <= prdata for reads; rdata unchanged for writes.
    - Go to DONE.
  - Each cycle with m_penable = 1 and PREADY = 0 increments the wait counter (saturating). When it reaches WAIT_LIMIT, stall = 1.
  - The arbiter never aborts a transfer.
- DONE:
  - done = gnt for exactly one cycle; rdata valid in this cycle.
  - last <= winner index. gnt <= 0. Wait counter <= 0.
  - Go to IDLE.
- Latency with PREADY already high: req seen at cycle 0 -> transfer at cycle 1 -> master SETUP at cycle 2 -> ACCESS at cycle 3 -> done at cycle 4.
  - Back-to-back requests: next grant in the cycle after DONE, so one IDLE cycle between transactions.
- A requester deasserting req while granted does not cancel the transaction; its done still pulses.
- Requests arriving mid-transaction are only evaluated in IDLE.
- Simultaneous requests are resolved purely by the round-robin pointer, and each requester wins at most once per rotation while the others are requesting.
- Reset mid-transaction returns everything to the reset values immediately. The master is reset by the same system reset, so no APB phase is orphaned.
- gnt and done are always zero or one-hot.

Test Plan:
- Single write: req=0001, rw=1, addr=0x3C, wdata=0xA5, PREADY=1 -> transfer high cycle 1; apb_write_paddr=0x3C, apb_write_data=0xA5 through ACCESS; done=0001 at cycle 4.
- Single read with wait states: req=0100, rw=0, addr=0x10; PREADY low for 3 ACCESS cycles then high with prdata=0x5A -> done=0100 with rdata=0x5A; stall stays 0.
- Fairness: req=1111 held and re-raised after each done -> grant order 0, 1, 2, 3, 0; no requester granted twice in a row.
- Stall: WAIT_LIMIT=16, PREADY held low for 20 ACCESS cycles -> stall=1 after the 16th; transaction then completes normally when PREADY rises; stall clears on the next grant.
- Request drop: requester 2 granted, req[2] falls during WAIT_ACCESS -> transaction completes; done=0100 still pulses.
- Reset mid-op: PRESET pulsed during WAIT_ACCESS -> all outputs 0 asynchronously; after release, req=1000 pending wins with requester 3 correctly chosen from pointer 3+1 = 0 scan order.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//   Round-robin arbiter and sequencer that lets four requesters share a single
//   APB master. The winner's command is latched and drives the master's
//   transfer, READ_WRITE, address and write-data inputs. The arbiter follows the
//   master's SETUP/ACCESS phases, captures read data and pulses done back to the
//   granted requester for one cycle.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req/req_rw            per-requester request level and direction (1 = write)
//   req_addr/req_wdata    packed per-requester address / write data
//   gnt/done              one-hot grant (whole transaction) / completion pulse
//   rdata                 read data, valid while done is high for a read
//   stall                 sticky: ACCESS phase waited WAIT_LIMIT cycles
//   transfer, READ_WRITE,
//   apb_write_paddr,
//   apb_write_data,
//   apb_read_paddr        command inputs of the APB master
//   m_psel, m_penable     phase indicators coming back from the master
//   PREADY, prdata        slave ready / read data shared with the master
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [3:0]            req,
  input  logic [3:0]            req_rw,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_wdata,
  output logic [3:0]            gnt,
  output logic [3:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  output logic                  transfer,
  output logic                  READ_WRITE,
  output logic [ADDR_W-1:0]     apb_write_paddr,
  output logic [DATA_W-1:0]     apb_write_data,
  output logic [ADDR_W-1:0]     apb_read_paddr,
  input  logic                  m_psel,
  input  logic                  m_penable,
  input  logic                  PREADY,
  input  logic [DATA_W-1:0]     prdata
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_SETUP  = 3'd2,
    S_WAIT_ACCESS = 3'd3,
    S_DONE        = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          win_q, win_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                stall_q, stall_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [1:0]          pick_s;
  logic                setup_seen_s;
  logic                access_done_s;

  // First set request bit scanning last+1, last+2, ... wrapping modulo 4.
  // Returns last when nothing is requested; callers only use it when req != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx     = last + 2'(i);
      rr_pick = (!found && r[idx]) ? idx : rr_pick;
      found   = found | r[idx];
    end
  endfunction

  assign pick_s        = rr_pick(req, last_q);
  assign setup_seen_s  = m_psel & ~m_penable;
  assign access_done_s = m_psel & m_penable & PREADY;

  // transfer is dropped in the very cycle the master shows SETUP, so the master
  // falls back to IDLE after ACCESS instead of chaining another transfer.
  assign transfer = (state_q == S_ISSUE) |
                    ((state_q == S_WAIT_SETUP) & ~setup_seen_s);

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign rdata           = rdata_q;
  assign stall           = stall_q;
  assign READ_WRITE      = rw_q;
  assign apb_write_paddr = addr_q;
  assign apb_read_paddr  = addr_q;
  assign apb_write_data  = wdata_q;

  // Next-state and datapath decode for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    done_d     = 4'b0000;
    rdata_d    = rdata_q;
    stall_d    = stall_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          win_d      = pick_s;
          gnt_d      = 4'b0001 << pick_s;
          rw_d       = req_rw[pick_s];
          addr_d     = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
          // Reads present zero on the write-data bus.
          wdata_d    = req_rw[pick_s] ? req_wdata[int'(pick_s)*DATA_W +: DATA_W]
                                      : {DATA_W{1'b0}};
          stall_d    = 1'b0;
          wait_cnt_d = 8'd0;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_SETUP;
      end
      S_WAIT_SETUP: begin
        if (setup_seen_s) begin
          state_d = S_WAIT_ACCESS;
        end else begin
          state_d = S_WAIT_SETUP;
        end
      end
      S_WAIT_ACCESS: begin
        if (access_done_s) begin
          if (!rw_q) begin
            rdata_d = prdata;
          end else begin
            rdata_d = rdata_q;
          end
          done_d  = gnt_q;
          state_d = S_DONE;
        end else if (m_penable && !PREADY) begin
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
          if (wait_cnt_d >= 8'(WAIT_LIMIT)) begin
            stall_d = 1'b1;
          end else begin
            stall_d = stall_q;
          end
        end else begin
          state_d = S_WAIT_ACCESS;
        end
      end
      S_DONE: begin
        last_d     = win_q;
        gnt_d      = 4'b0000;
        wait_cnt_d = 8'd0;
        state_d    = S_IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset puts the pointer at 3 so requester 0 leads.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      last_q     <= 2'd3;
      win_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      done_q     <= 4'b0000;
      rdata_q    <= {DATA_W{1'b0}};
      stall_q    <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      stall_q    <= stall_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//   Directed, table-driven bench for apb_master_arbiter with a small behavioural
//   APB master (IDLE/SETUP/ACCESS) closing the m_psel/m_penable loop.
//   Inputs are driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  req, req_rw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  gnt, done;
  logic [7:0]  rdata;
  logic        stall, transfer, READ_WRITE;
  logic [7:0]  apb_write_paddr, apb_write_data, apb_read_paddr;
  logic        m_psel, m_penable, PREADY;
  logic [7:0]  prdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_LIMIT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .stall(stall), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .m_psel(m_psel), .m_penable(m_penable),
    .PREADY(PREADY), .prdata(prdata)
  );

  always #5 PCLK = ~PCLK;

  // Behavioural APB master: 0 = IDLE, 1 = SETUP, 2 = ACCESS.
  logic [1:0] m_st;
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) m_st <= 2'd0;
    else begin
      case (m_st)
        2'd0:    m_st <= transfer ? 2'd1 : 2'd0;
        2'd1:    m_st <= 2'd2;
        2'd2:    m_st <= PREADY ? (transfer ? 2'd1 : 2'd0) : 2'd2;
        default: m_st <= 2'd0;
      endcase
    end
  end
  assign m_psel    = (m_st != 2'd0);
  assign m_penable = (m_st == 2'd2);

  typedef struct {
    int         k;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    int         waits;
    logic [3:0] exp_gnt;
    logic [7:0] exp_wd;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req = 4'b0000; req_rw = 4'b0000; req_addr = 32'd0; req_wdata = 32'd0;
    PREADY = 1'b1; prdata = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    step();
  endtask

  // One isolated transaction from IDLE; cycle numbers relative to req seen.
  task automatic run_vec(input vec_t v);
    clear_inputs();
    req_rw[v.k]              = v.rw;
    req_addr[v.k*8 +: 8]     = v.addr;
    req_wdata[v.k*8 +: 8]    = v.wdata;
    PREADY                   = (v.waits == 0);
    prdata                   = v.prdata;
    req[v.k]                 = 1'b1;
    step();                                   // cycle 1: ISSUE
    chk("vec_gnt",      gnt, v.exp_gnt);
    chk("vec_transfer", transfer, 1'b1);
    chk("vec_rw",       READ_WRITE, v.rw);
    chk("vec_wpaddr",   apb_write_paddr, v.addr);
    chk("vec_rpaddr",   apb_read_paddr, v.addr);
    chk("vec_wdata",    apb_write_data, v.exp_wd);
    step();                                   // cycle 2: master SETUP
    chk("vec_setup_xfer_low", transfer, 1'b0);
    step();                                   // cycle 3: first ACCESS
    chk("vec_access_addr", apb_write_paddr, v.addr);
    chk("vec_access_done_low", done, 4'b0000);
    repeat (v.waits) step();
    PREADY = 1'b1;
    step();                                   // DONE cycle
    chk("vec_done",  done, v.exp_gnt);
    chk("vec_rdata", rdata, v.exp_rdata);
    chk("vec_stall", stall, 1'b0);
    req = 4'b0000;
    step();                                   // back in IDLE
    chk("vec_done_pulse_end", done, 4'b0000);
    chk("vec_gnt_release",    gnt, 4'b0000);
  endtask

  initial begin
    // Hand-computed vectors; each runs alone so the winner is its own index.
    vecs[0] = '{k:0, rw:1'b1, addr:8'h3C, wdata:8'hA5, prdata:8'hEE, waits:0,
                exp_gnt:4'b0001, exp_wd:8'hA5, exp_rdata:8'h00};
    vecs[1] = '{k:2, rw:1'b0, addr:8'h10, wdata:8'hFF, prdata:8'h5A, waits:3,
                exp_gnt:4'b0100, exp_wd:8'h00, exp_rdata:8'h5A};
    vecs[2] = '{k:3, rw:1'b1, addr:8'hC3, wdata:8'h0F, prdata:8'h99, waits:1,
                exp_gnt:4'b1000, exp_wd:8'h0F, exp_rdata:8'h5A};
    vecs[3] = '{k:1, rw:1'b0, addr:8'h7E, wdata:8'h00, prdata:8'h81, waits:2,
                exp_gnt:4'b0010, exp_wd:8'h00, exp_rdata:8'h81};

    clear_inputs();
    PRESET = 1'b1;
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_transfer", transfer, 1'b0);
    chk("rst_rw", READ_WRITE, 1'b0);
    chk("rst_wpaddr", apb_write_paddr, 8'h00);
    chk("rst_wdata", apb_write_data, 8'h00);
    PRESET = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset in the middle of a waiting write from requester 1.
    clear_inputs();
    req = 4'b0010; req_rw = 4'b0010; req_addr[15:8] = 8'h55; req_wdata[15:8] = 8'h66;
    PREADY = 1'b0;
    step(); step(); step(); step();           // two ACCESS cycles in
    chk("mid_gnt_before", gnt, 4'b0010);
    req = 4'b1000; req_rw = 4'b0000; req_addr = 32'd0; req_addr[31:24] = 8'hA0;
    prdata = 8'h44;
    PRESET = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_transfer", transfer, 1'b0);
    chk("mid_rst_rw", READ_WRITE, 1'b0);
    chk("mid_rst_wpaddr", apb_write_paddr, 8'h00);
    chk("mid_rst_rpaddr", apb_read_paddr, 8'h00);
    chk("mid_rst_wdata", apb_write_data, 8'h00);
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_done", done, 4'b0000);
    step();
    PRESET = 1'b0; PREADY = 1'b1;
    step();                                   // ISSUE for requester 3
    chk("mid_after_gnt", gnt, 4'b1000);
    chk("mid_after_rpaddr", apb_read_paddr, 8'hA0);
    step(); step(); step();
    chk("mid_after_done", done, 4'b1000);
    chk("mid_after_rdata", rdata, 8'h44);
    req = 4'b0000;
    step();

    // Fairness: all four requesting continuously from the reset pointer.
    do_reset();
    req = 4'b1111; req_rw = 4'b0000; PREADY = 1'b1;
    for (int n = 0; n < 5; n++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (n % 4);
      step();
      chk("rr_gnt", gnt, exp_g);
      step(); step(); step();
      chk("rr_done", done, exp_g);
      if (n == 4) req = 4'b0000;
      step();
      chk("rr_idle_gap", gnt, 4'b0000);
    end

    // Stall: 20 low ACCESS cycles with WAIT_LIMIT = 16.
    do_reset();
    req = 4'b0010; req_rw = 4'b0010; req_addr[15:8] = 8'h22; req_wdata[15:8] = 8'h77;
    PREADY = 1'b0;
    step(); step(); step();                   // ACCESS cycle k = 1
    for (int k = 1; k <= 20; k++) begin
      if (k == 16) chk("stall_before_limit", stall, 1'b0);
      if (k == 17) chk("stall_at_limit", stall, 1'b1);
      step();
    end
    PREADY = 1'b1;
    step();
    chk("stall_done", done, 4'b0010);
    chk("stall_sticky_done", stall, 1'b1);
    req = 4'b0001; req_rw = 4'b0000; req_addr = 32'd0; req_addr[7:0] = 8'h01;
    step();
    chk("stall_sticky_idle", stall, 1'b1);
    step();
    chk("stall_next_gnt", gnt, 4'b0001);
    chk("stall_cleared", stall, 1'b0);
    step(); step(); step();
    chk("stall_next_done", done, 4'b0001);
    req = 4'b0000;
    step();

    // Request dropped while granted: transaction still completes.
    do_reset();
    req = 4'b0100; req_addr[23:16] = 8'h10; PREADY = 1'b0;
    step();
    chk("drop_gnt", gnt, 4'b0100);
    step(); step();
    req = 4'b0000;
    step();
    PREADY = 1'b1; prdata = 8'h3C;
    step();
    chk("drop_done", done, 4'b0100);
    chk("drop_rdata", rdata, 8'h3C);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
